weight_col_sequencer: RTL and testbench
=======================================

Name: weight_col_sequencer

Overview:
- Controller that sequences one matrix-vector pass over the column-addressed weight RAM.
- On start it sweeps the RAM column address 0..NCOL-1, one column per cycle. It emits MAC control (clear/enable/last plus the input-vector element index) aligned to the RAM read data.
- It then waits for the MAC pipeline to drain and holds a result-valid handshake until the consumer accepts.
- Sits between the layer-level FSM (start/done) and the weight RAM plus row-parallel MAC array.

Parameters:
- NCOL, 16, number of weight-RAM columns (input-vector length) swept per pass; must be >= 1.
- ADDR_BITWIDTH, 4, width of ram_addr and x_index; must hold NCOL-1.
- RAM_LATENCY, 1, cycles from ram_addr change (posedge) to rowOutput usable at a posedge. It is 1 for a negedge-read RAM. Must be >= 1.
- MAC_LATENCY, 1, cycles after the edge that samples the last mac_en until the MAC result is stable. Must be >= 1.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, request a pass; sampled only in IDLE.
- busy, output, 1, high whenever the state is not IDLE.
- done, output, 1, one-cycle pulse after the result is accepted.
- ram_addr, output, ADDR_BITWIDTH, weight-RAM column address.
- x_index, output, ADDR_BITWIDTH, input-vector element index, aligned with mac_en.
- mac_en, output, 1, accumulate the current rowOutput × x[x_index].
- mac_clear, output, 1, load instead of add; coincides with the first mac_en of a pass.
- mac_last, output, 1, coincides with the last mac_en of a pass.
- result_valid, output, 1, MAC result is stable and may be read.
- result_ready, input, 1, consumer accepts the result.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, all outputs 0, column counter 0, alignment pipeline cleared.
- Reset mid-pass: aborts immediately. No further mac_en/mac_clear/mac_last pulses appear and no done is issued.
- States: IDLE, RUN, DRAIN, RESULT.
- IDLE -> RUN: on an edge sampling start=1. At that edge ram_addr<=0 and counter<=0.
- RUN:
  - Each edge increments ram_addr.
  - An issue token (first = counter==0, last = counter==NCOL-1) enters a RAM_LATENCY-deep shift pipe, together with the issued address.
  - At the edge where counter==NCOL-1: go to DRAIN and load the drain counter with RAM_LATENCY+MAC_LATENCY-1.
  - ram_addr holds NCOL-1 after the sweep (no wrap).
- Pipe outputs drive mac_en, mac_clear (first), mac_last (last) and x_index (delayed address). x_index holds its last value when mac_en=0.
- DRAIN: decrement the drain counter each edge. At zero go to RESULT and set result_valid=1.
- RESULT:
  - result_valid stays high until an edge sampling result_ready=1.
  - At that edge: result_valid<=0, done<=1 for one cycle, state<=IDLE.
  - result_ready while result_valid=0 is ignored.
- Latency (start-sampling edge = edge 0):
  - ram_addr=k after edge k.
  - mac_en high after edges RAM_LATENCY .. RAM_LATENCY+NCOL-1.
  - result_valid first high after edge NCOL+RAM_LATENCY+MAC_LATENCY-1.
- start while busy is ignored; there is no queueing.
- Back-to-back: start may be high during the done cycle (state already IDLE) and is accepted. busy=0 during the done cycle.
- NCOL=1: mac_clear and mac_last assert in the same cycle as the single mac_en.
- Exactly NCOL mac_en pulses per pass, contiguous, with no gaps.

Decomposition:
- Shared package: state encoding constants (IDLE/RUN/DRAIN/RESULT) and a clog2-style helper for ADDR_BITWIDTH checks, reused by other sequencers.
- One natural sub-module: align_pipe, a generic RAM_LATENCY-deep register pipe carrying {first, last, valid, addr} with synchronous clear. It is reused wherever RAM read latency must be matched.

Test Plan:
- Defaults; start pulse at edge 0, result_ready held 1 -> ram_addr 0..15 after edges 0..15; mac_en high after edges 1..16 with x_index 0..15; mac_clear only after edge 1; mac_last only after edge 16; result_valid high after edge 17; done pulse after edge 18; busy high after edges 0..17.
- Backpressure: result_ready=0 for 5 cycles after result_valid rises -> result_valid held steady, no done; done pulses one cycle after the edge where result_ready=1.
- Start while busy: start pulsed at edges 3 and 10 of a pass -> ignored; exactly 16 mac_en pulses; single done.
- Back-to-back: start high during the done cycle -> new pass begins; ram_addr=0 on the following cycle; second pass timing identical to the first.
- Reset mid-pass: reset at edge 8 -> after edge 8 all outputs 0, state IDLE, no mac_en afterwards, no done; a fresh start then yields a normal pass.
- NCOL=1, RAM_LATENCY=2, MAC_LATENCY=3 -> one mac_en after edge 2 with mac_clear=mac_last=1 and x_index=0; result_valid first high after edge 5.

Source files
------------

// File: rtl/weight_col_seq_pkg.sv
// ============================================================================
// Module  : weight_col_seq_pkg
// Brief   : Shared state encoding and width helper for column sequencers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package weight_col_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } seq_state_e;

  // Bits needed to hold count-1 (at least one bit).
  function automatic int addr_bits(input int count);
    int bits;
    bits = 1;
    while ((1 << bits) < count) bits++;
    return bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/weight_col_sequencer_align_pipe.sv
// ============================================================================
// Module  : align_pipe
// Brief   : DEPTH-deep register pipe carrying {first, last, valid, addr}.
// Revision: 1.0
// ============================================================================
`default_nettype none

module align_pipe #(
  parameter int DEPTH = 1,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic          out_first,
  output logic          out_last,
  output logic [AW-1:0] out_addr
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_first;
  logic [DEPTH-1:0] r_last;
  logic [AW-1:0]    r_addr [DEPTH];

  // Address stages only load behind a valid token, so the tail holds the last index.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_valid <= '0;
      r_first <= '0;
      r_last  <= '0;
      for (int d = 0; d < DEPTH; d++) r_addr[d] <= '0;
    end else begin
      r_valid[0] <= in_valid;
      r_first[0] <= in_valid & in_first;
      r_last[0]  <= in_valid & in_last;
      if (in_valid) r_addr[0] <= in_addr;
      for (int d = 1; d < DEPTH; d++) begin
        r_valid[d] <= r_valid[d-1];
        r_first[d] <= r_first[d-1];
        r_last[d]  <= r_last[d-1];
        if (r_valid[d-1]) r_addr[d] <= r_addr[d-1];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_first = r_first[DEPTH-1];
  assign out_last  = r_last[DEPTH-1];
  assign out_addr  = r_addr[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/weight_col_sequencer.sv
// ============================================================================
// Module  : weight_col_sequencer
// Brief   : Sweeps weight-RAM columns and issues RAM-aligned MAC control.
// Revision: 1.0
// ============================================================================
`default_nettype none

module weight_col_sequencer
  import weight_col_seq_pkg::*;
#(
  parameter int NCOL          = 16,
  parameter int ADDR_BITWIDTH = 4,
  parameter int RAM_LATENCY   = 1,
  parameter int MAC_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_BITWIDTH-1:0] ram_addr,
  output logic [ADDR_BITWIDTH-1:0] x_index,
  output logic                     mac_en,
  output logic                     mac_clear,
  output logic                     mac_last,
  output logic                     result_valid,
  input  logic                     result_ready
);

  localparam int DRAIN_W = addr_bits(RAM_LATENCY + MAC_LATENCY);
  localparam logic [ADDR_BITWIDTH-1:0] C_LAST_COL   = ADDR_BITWIDTH'(NCOL - 1);
  localparam logic [DRAIN_W-1:0]       C_DRAIN_INIT = DRAIN_W'(RAM_LATENCY + MAC_LATENCY - 1);

  if (ADDR_BITWIDTH < addr_bits(NCOL)) begin : g_width_check
    $error("ADDR_BITWIDTH too small to address NCOL columns");
  end

  seq_state_e               r_state;
  logic [ADDR_BITWIDTH-1:0] r_col;
  logic [DRAIN_W-1:0]       r_drain;
  logic                     w_issue;

  assign w_issue = (r_state == ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_drain      <= '0;
      ram_addr     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_RUN;
            busy     <= 1'b1;
            ram_addr <= '0;
            r_col    <= '0;
          end
        end
        ST_RUN: begin
          // Address saturates at the last column instead of wrapping.
          if (r_col == C_LAST_COL) begin
            r_state <= ST_DRAIN;
            r_drain <= C_DRAIN_INIT;
          end else begin
            r_col    <= r_col + ADDR_BITWIDTH'(1);
            ram_addr <= ram_addr + ADDR_BITWIDTH'(1);
          end
        end
        ST_DRAIN: begin
          r_drain <= r_drain - DRAIN_W'(1);
          if (r_drain == DRAIN_W'(1)) begin
            r_state      <= ST_RESULT;
            result_valid <= 1'b1;
          end
        end
        ST_RESULT: begin
          if (result_ready) begin
            r_state      <= ST_IDLE;
            result_valid <= 1'b0;
            done         <= 1'b1;
            busy         <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  align_pipe #(
    .DEPTH (RAM_LATENCY),
    .AW    (ADDR_BITWIDTH)
  ) u_align (
    .clk       (clk),
    .clear     (reset),
    .in_valid  (w_issue),
    .in_first  (r_col == '0),
    .in_last   (r_col == C_LAST_COL),
    .in_addr   (ram_addr),
    .out_valid (mac_en),
    .out_first (mac_clear),
    .out_last  (mac_last),
    .out_addr  (x_index)
  );

endmodule

`default_nettype wire

// File: tb/tb_weight_col_sequencer.sv
// ============================================================================
// Module  : tb_weight_col_sequencer
// Brief   : Two sequencer configurations driven in lockstep against a pass model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_weight_col_sequencer;

  logic clk = 1'b0;
  logic reset, start, result_ready;

  logic [1:0] busy_s, done_s, men_s, clr_s, lst_s, rv_s;
  logic [3:0] ra_s [2];
  logic [3:0] xi_s [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  weight_col_sequencer #(.NCOL(16), .ADDR_BITWIDTH(4), .RAM_LATENCY(1), .MAC_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_s[0]), .done(done_s[0]),
    .ram_addr(ra_s[0]), .x_index(xi_s[0]), .mac_en(men_s[0]), .mac_clear(clr_s[0]),
    .mac_last(lst_s[0]), .result_valid(rv_s[0]), .result_ready(result_ready)
  );

  weight_col_sequencer #(.NCOL(1), .ADDR_BITWIDTH(4), .RAM_LATENCY(2), .MAC_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_s[1]), .done(done_s[1]),
    .ram_addr(ra_s[1]), .x_index(xi_s[1]), .mac_en(men_s[1]), .mac_clear(clr_s[1]),
    .mac_last(lst_s[1]), .result_valid(rv_s[1]), .result_ready(result_ready)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pass model: position within a pass measured in edges since the start edge.
  int  ncol_m [2] = '{16, 1};
  int  rl_m   [2] = '{1, 2};
  int  ml_m   [2] = '{1, 3};
  bit  act [2], val [2], dn [2], men [2], clr [2], lst [2];
  int  rel [2], ra [2], xi [2];
  bit  armed = 1'b0;
  bit  s_rst, s_st, s_rdy;

  always @(posedge clk) begin
    s_rst = reset; s_st = start; s_rdy = result_ready;
    if (s_rst) armed = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (s_rst) begin
        act[i] = 0; val[i] = 0; dn[i] = 0; ra[i] = 0; xi[i] = 0; rel[i] = 0;
      end else begin
        dn[i] = 0;
        if (act[i] && val[i] && s_rdy) begin
          val[i] = 0; dn[i] = 1; act[i] = 0;
        end else if (!act[i] && s_st) begin
          act[i] = 1; rel[i] = 0;
        end else if (act[i]) begin
          rel[i]++;
          if (rel[i] == ncol_m[i] + rl_m[i] + ml_m[i] - 1) val[i] = 1;
        end
        if (act[i]) ra[i] = (rel[i] < ncol_m[i]) ? rel[i] : ncol_m[i] - 1;
      end
      men[i] = act[i] && rel[i] >= rl_m[i] && rel[i] <= rl_m[i] + ncol_m[i] - 1;
      clr[i] = men[i] && rel[i] == rl_m[i];
      lst[i] = men[i] && rel[i] == rl_m[i] + ncol_m[i] - 1;
      if (men[i]) xi[i] = rel[i] - rl_m[i];
    end
    #1;
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dut%0d busy", i), busy_s[i], act[i]);
        check($sformatf("dut%0d done", i), done_s[i], dn[i]);
        check($sformatf("dut%0d ram_addr", i), ra_s[i], ra[i]);
        check($sformatf("dut%0d x_index", i), xi_s[i], xi[i]);
        check($sformatf("dut%0d mac_en", i), men_s[i], men[i]);
        check($sformatf("dut%0d mac_clear", i), clr_s[i], clr[i]);
        check($sformatf("dut%0d mac_last", i), lst_s[i], lst[i]);
        check($sformatf("dut%0d result_valid", i), rv_s[i], val[i]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // sel 0 waits for done of dut0, sel 1 for result_valid of dut0.
  task automatic wait_sig(input int sel, input int maxc, output int used);
    used = 0;
    while (((sel == 0) ? done_s[0] : rv_s[0]) != 1'b1 && used < maxc) begin
      step(1);
      used++;
    end
    check((sel == 0) ? "wait_done_bound" : "wait_valid_bound",
          (sel == 0) ? done_s[0] : rv_s[0], 1);
  endtask

  int n_en, n_done, used;

  initial begin
    reset = 1'b1; start = 1'b0; result_ready = 1'b1;
    step(3);
    reset = 1'b0;
    check("reset_busy", busy_s[0], 0);
    check("reset_addr", ra_s[0], 0);
    step(1);

    // Basic pass, both configurations
    start = 1'b1; step(1); start = 1'b0;
    check("t1_addr_e0", ra_s[0], 0);
    check("t1_busy_e0", busy_s[0], 1);
    step(2);
    check("ncol1_en_e2", men_s[1], 1);
    check("ncol1_clear_e2", clr_s[1], 1);
    check("ncol1_last_e2", lst_s[1], 1);
    check("ncol1_x_e2", xi_s[1], 0);
    step(3);
    check("ncol1_valid_e5", rv_s[1], 1);
    step(11);
    check("t1_last_e16", lst_s[0], 1);
    check("t1_x_e16", xi_s[0], 15);
    step(1);
    check("t1_valid_e17", rv_s[0], 1);
    step(1);
    check("t1_done_e18", done_s[0], 1);
    check("t1_busy_e18", busy_s[0], 0);
    step(3);

    // Backpressure
    result_ready = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    wait_sig(1, 40, used);
    step(5);
    check("bp_valid_held", rv_s[0], 1);
    check("bp_no_done", done_s[0], 0);
    result_ready = 1'b1;
    step(1);
    check("bp_done", done_s[0], 1);
    step(3);

    // Start while busy
    start = 1'b1; step(1); start = 1'b0;
    n_en = 0; n_done = 0;
    for (int e = 1; e <= 30; e++) begin
      start = (e == 3 || e == 10);
      step(1);
      start = 1'b0;
      n_en += int'(men_s[0]);
      n_done += int'(done_s[0]);
    end
    check("busy_start_mac_en_count", n_en, 16);
    check("busy_start_done_count", n_done, 1);

    // Back-to-back
    start = 1'b1;
    wait_sig(0, 40, used);
    step(1);
    check("b2b_addr", ra_s[0], 0);
    check("b2b_busy", busy_s[0], 1);
    wait_sig(0, 40, used);
    check("b2b_gap", used, 18);
    start = 1'b0;
    step(25);

    // Reset mid-pass
    start = 1'b1; step(1); start = 1'b0;
    step(7);
    reset = 1'b1; step(1); reset = 1'b0;
    check("rst_mac_en", men_s[0], 0);
    check("rst_addr", ra_s[0], 0);
    check("rst_busy", busy_s[0], 0);
    n_en = 0; n_done = 0;
    for (int e = 0; e < 20; e++) begin
      step(1);
      n_en += int'(men_s[0]);
      n_done += int'(done_s[0]);
    end
    check("rst_no_mac_en", n_en, 0);
    check("rst_no_done", n_done, 0);
    start = 1'b1; step(1); start = 1'b0;
    wait_sig(0, 40, used);
    check("rst_fresh_pass_len", used, 18);
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
